// File: rtl/sar_conv_ctrl.sv
// Sequencing controller for one time-domain SAR ADC channel:
// sample window, per-bit DAC trial/compare, end-of-conversion.
`timescale 1ns/1ps
module sar_conv_ctrl #(
   parameter int NBITS   = 8,
   parameter int SAMP_W  = 4,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              trig,
   input  logic              cont,
   input  logic [SAMP_W-1:0] samp_cycles,
   input  logic              comp_valid,
   input  logic              comp_out,
   output logic              samp,
   output logic              start,
   output logic [NBITS-1:0]  dac_code,
   output logic              eoc,
   output logic [NBITS-1:0]  dout,
   output logic              dout_valid,
   output logic              busy,
   output logic              timeout_err
);

   localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [IW-1:0] IDX_MSB = IW'(NBITS - 1);
   localparam logic [TW-1:0] TLAST   = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SAMPLE,
      S_SETTLE,
      S_COMPARE,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   logic [SAMP_W-1:0] samp_cnt;
   logic [IW-1:0]     idx;
   logic [TW-1:0]     tcnt;
   logic [NBITS-1:0]  result;
   logic [NBITS-1:0]  res_upd;
   logic [NBITS-1:0]  trial;
   logic              go;
   logic              decide;
   logic              forced;

   assign trial = result | (NBITS'(1) << idx);

   always_comb begin
      state_nxt = state;
      go        = 1'b0;
      decide    = 1'b0;
      forced    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (trig | cont) begin
               state_nxt = S_SAMPLE;
               go        = 1'b1;
            end
         end
         S_SAMPLE: begin
            if (samp_cnt <= SAMP_W'(1))
               state_nxt = S_SETTLE;
         end
         S_SETTLE: state_nxt = S_COMPARE;
         S_COMPARE: begin
            // a decision arriving in the last allowed cycle beats the timeout
            if (comp_valid) begin
               decide = 1'b1;
            end else if (tcnt == TLAST) begin
               decide = 1'b1;
               forced = 1'b1;
            end
            if (decide)
               state_nxt = (idx == '0) ? S_DONE : S_SETTLE;
         end
         S_DONE: begin
            if (cont) begin
               state_nxt = S_SAMPLE;
               go        = 1'b1;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      if (!en) begin
         state_nxt = S_IDLE;
         go        = 1'b0;
         decide    = 1'b0;
         forced    = 1'b0;
      end
   end

   always_comb begin
      res_upd      = result;
      res_upd[idx] = comp_valid & comp_out;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         samp_cnt    <= '0;
         idx         <= IDX_MSB;
         tcnt        <= '0;
         result      <= '0;
         dout        <= '0;
         timeout_err <= 1'b0;
      end else begin
         state <= state_nxt;
         if (go) begin
            samp_cnt    <= (samp_cycles == '0) ? SAMP_W'(1) : samp_cycles;
            result      <= '0;
            timeout_err <= 1'b0;
            idx         <= IDX_MSB;
         end else if (state == S_SAMPLE) begin
            samp_cnt <= samp_cnt - SAMP_W'(1);
         end
         if (state == S_SETTLE)
            tcnt <= '0;
         else if (state == S_COMPARE)
            tcnt <= tcnt + TW'(1);
         // dout is loaded with the final bit so it is valid during DONE
         if (decide) begin
            result <= res_upd;
            if (forced)
               timeout_err <= 1'b1;
            if (idx != '0)
               idx <= idx - IW'(1);
            else
               dout <= res_upd;
         end
      end
   end

   assign samp       = (state == S_SAMPLE);
   assign start      = (state == S_COMPARE);
   assign eoc        = (state == S_DONE);
   assign dout_valid = (state == S_DONE);
   assign busy       = (state != S_IDLE);
   assign dac_code   = (state == S_SETTLE || state == S_COMPARE) ? trial :
                       (state == S_DONE) ? result : '0;

endmodule

// File: doc/sar_conv_ctrl.md
Name: sar_conv_ctrl

Overview:
- Sequencing controller for one time-domain SAR ADC channel.
- Runs each conversion through its phases: sampling window, then a per-bit DAC trial, comparator start and decision, then end-of-conversion.
- Drives the comparator's samp/start strobes and the capacitive DAC code, and collects the time-domain comparator's decisions.
- Produces a registered result word with a valid pulse; supports single-shot and continuous operation.

Parameters:
- NBITS, 8, resolution; width of dac_code and dout.
- SAMP_W, 4, width of the samp_cycles configuration field.
- TIMEOUT, 15, maximum number of COMPARE cycles to wait for comp_valid before a forced decision.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  block enable; low aborts any conversion and holds IDLE.
- trig  in  1  single-conversion request, level-sampled in IDLE.
- cont  in  1  continuous mode; a new conversion starts automatically after DONE.
- samp_cycles  in  SAMP_W  sampling window length in clocks; 0 is treated as 1.
- comp_valid  in  1  comparator decision ready; honoured only while start=1.
- comp_out  in  1  comparator decision; 1 means vin >= DAC, so the bit is kept.
- samp  out  1  sample switch enable.
- start  out  1  comparator start strobe.
- dac_code  out  NBITS  DAC trial code.
- eoc  out  1  end of conversion, 1-cycle pulse.
- dout  out  NBITS  last conversion result.
- dout_valid  out  1  1-cycle pulse coincident with eoc.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky flag for a forced decision in the current or last conversion.

Behaviour:

Reset (rst_n=0):
- state=IDLE.
- samp, start, eoc, dout_valid, busy, timeout_err = 0.
- dac_code = 0, dout = 0, bit index = NBITS-1, all counters = 0.

States:
- IDLE
  - Outputs low.
  - If en and (trig or cont): go to SAMPLE; load samp counter with max(samp_cycles,1); clear timeout_err and the result register.
- SAMPLE
  - samp=1 for exactly max(samp_cycles,1) cycles, then go to SETTLE with bit index = NBITS-1.
- SETTLE
  - Lasts 1 cycle; start=0, samp=0.
  - dac_code = result | (1<<idx); this value is driven from this cycle onward.
  - Next state is COMPARE; timeout counter cleared.
- COMPARE
  - start=1; dac_code held stable.
  - On comp_valid:
    - result[idx] = comp_out.
    - If idx==0, go to DONE; otherwise idx-1 and go to SETTLE.
  - If no comp_valid after TIMEOUT cycles in COMPARE: force result[idx]=0, set timeout_err, then advance exactly as above.
  - comp_valid in the timeout cycle itself wins over the timeout.
- DONE
  - Lasts 1 cycle; eoc=1, dout_valid=1, dout <= result, start=0, dac_code = result.
  - Next is IDLE, or SAMPLE directly if en and cont, so there is no idle gap in continuous mode.

Latency:
- With immediate comp_valid, conversion time is samp_cycles + 2*NBITS + 1 clocks, from the first SAMPLE cycle to eoc inclusive.
- Example: samp_cycles=4, NBITS=8 gives 21 cycles.

Boundary conditions:
- trig held high in single mode: a new conversion starts after each return to IDLE; trig is level-sensitive.
- trig during a conversion is ignored and not queued.
- comp_valid outside COMPARE is ignored.
- en low in any state:
  - Next cycle the state is IDLE.
  - samp, start, busy and dac_code go to 0.
  - No eoc pulse.
  - dout and timeout_err are retained.
- cont deasserted mid-conversion: the conversion completes and DONE goes to IDLE.
- samp and start are never high in the same cycle; start is always low for at least one cycle between bits.
- Asynchronous reset mid-conversion: immediate return to the reset values listed above.

Test Plan:
- Reset and idle
  - Stimulus: rst_n=0 with random inputs, then release with en=0 and trig=1 for 10 cycles.
  - Required: all outputs 0, busy=0.
- Single conversion, comparator model vin=8'hA5
  - Stimulus: samp_cycles=4, comp_valid returned on the first COMPARE cycle.
  - Required:
    - samp high for 4 cycles.
    - dac_code trial sequence 80,C0,A0,B0,A8,A4,A6,A5.
    - eoc and dout_valid at cycle 21; dout=A5; timeout_err=0.
- Timeout
  - Stimulus: comparator silent on bit 5 only, vin=8'hFF, TIMEOUT=15.
  - Required: bit 5 COMPARE lasts 15 cycles; dout=8'hDF; timeout_err=1, cleared at the next SAMPLE.
- Continuous mode
  - Stimulus: cont=1, samp_cycles=0, vin stepping 00 then FF then 5A.
  - Required:
    - samp lasts 1 cycle.
    - eoc every 18 cycles, back to back.
    - dout = 00, FF, 5A.
- Abort
  - Stimulus: en dropped in the COMPARE cycle of bit 3.
  - Required:
    - IDLE next cycle; start=0, dac_code=0.
    - No eoc.
    - dout keeps the previous value.
- Protocol checks
  - Stimulus: spurious comp_valid during SAMPLE and SETTLE; trig pulsed mid-conversion.
  - Required:
    - Result unaffected; no extra conversion started.
    - Assertion holds that samp and start are never both high.
